// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one combinational ALU between two requesters
module alu_arbiter #(
   parameter int WIDTH = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0,
   input  logic             req1,
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] b0,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] b1,
   input  logic [2:0]       sel0,
   input  logic [2:0]       sel1,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [2:0]       alu_sel,
   input  logic [WIDTH-1:0] alu_z,
   input  logic             alu_ovf,
   input  logic             alu_cout,
   output logic             gnt0,
   output logic             gnt1,
   output logic             done0,
   output logic             done1,
   output logic [WIDTH-1:0] result,
   output logic             ovf,
   output logic             cout,
   output logic             busy
);
   typedef enum logic [1:0] {IDLE, GRANT, DONE} state_t;
   state_t           state_q, state_d;
   logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d, result_q, result_d;
   logic [2:0]       alu_sel_q, alu_sel_d;
   logic [1:0]       gnt_q, gnt_d, done_q, done_d;
   logic             ovf_q, ovf_d, cout_q, cout_d, last_q, last_d, win;
   // on a tie the requester not granted last wins
   assign win = (req0 & req1) ? ~last_q : req1;
   always_comb begin
      state_d   = state_q;
      alu_a_d   = alu_a_q;
      alu_b_d   = alu_b_q;
      alu_sel_d = alu_sel_q;
      gnt_d     = gnt_q;
      done_d    = 2'b00;
      result_d  = result_q;
      ovf_d     = ovf_q;
      cout_d    = cout_q;
      last_d    = last_q;
      case (state_q)
         IDLE: if (req0 | req1) begin
            alu_a_d   = win ? a1 : a0;
            alu_b_d   = win ? b1 : b0;
            alu_sel_d = win ? sel1 : sel0;
            gnt_d     = win ? 2'b10 : 2'b01;
            last_d    = win;
            state_d   = GRANT;
         end
         GRANT: begin
            result_d = alu_z;
            ovf_d    = alu_ovf;
            cout_d   = alu_cout;
            done_d   = gnt_q;
            state_d  = DONE;
         end
         DONE: begin
            gnt_d   = 2'b00;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         alu_a_q   <= '0;
         alu_b_q   <= '0;
         alu_sel_q <= '0;
         gnt_q     <= '0;
         done_q    <= '0;
         result_q  <= '0;
         ovf_q     <= 1'b0;
         cout_q    <= 1'b0;
         last_q    <= 1'b1;
      end else begin
         state_q   <= state_d;
         alu_a_q   <= alu_a_d;
         alu_b_q   <= alu_b_d;
         alu_sel_q <= alu_sel_d;
         gnt_q     <= gnt_d;
         done_q    <= done_d;
         result_q  <= result_d;
         ovf_q     <= ovf_d;
         cout_q    <= cout_d;
         last_q    <= last_d;
      end
   end
   assign alu_a   = alu_a_q;
   assign alu_b   = alu_b_q;
   assign alu_sel = alu_sel_q;
   assign gnt0    = gnt_q[0];
   assign gnt1    = gnt_q[1];
   assign done0   = done_q[0];
   assign done1   = done_q[1];
   assign result  = result_q;
   assign ovf     = ovf_q;
   assign cout    = cout_q;
   assign busy    = state_q != IDLE;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed checks of alu_arbiter against an XNOR model of the shared ALU
module tb_alu_arbiter;
   logic       clk = 1'b0, reset = 1'b1, req0 = 1'b0, req1 = 1'b0, zforce = 1'b0;
   logic [5:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0, alu_a, alu_b, alu_z, result;
   logic [2:0] sel0 = '0, sel1 = '0, alu_sel;
   logic       gnt0, gnt1, done0, done1, ovf, cout, busy;
   int         checks = 0, failures = 0;
   always #5 clk = ~clk;
   assign alu_z = zforce ? 6'b111111 : ~(alu_a ^ alu_b);
   alu_arbiter #(.WIDTH(6)) dut (
      .clk(clk), .reset(reset), .req0(req0), .req1(req1),
      .a0(a0), .b0(b0), .a1(a1), .b1(b1), .sel0(sel0), .sel1(sel1),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
      .alu_z(alu_z), .alu_ovf(1'b0), .alu_cout(1'b0),
      .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
      .result(result), .ovf(ovf), .cout(cout), .busy(busy)
   );
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic check_zero(input string tag);
      check({tag, "_gnt"}, {gnt1, gnt0}, 0);
      check({tag, "_done"}, {done1, done0}, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_res"}, {ovf, cout, result}, 0);
      check({tag, "_alu"}, {alu_sel, alu_b, alu_a}, 0);
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end
   initial begin
      logic [1:0] exp_g;
      logic [5:0] exp_a, exp_b;
      repeat (2) @(negedge clk);
      check_zero("reset");
      reset = 1'b0;
      // single request from requester 0
      req0 = 1'b1; a0 = 6'b101010; b0 = 6'b100110; sel0 = 3'd5;
      @(negedge clk);
      check("s_gnt", {gnt1, gnt0}, 2'b01);
      check("s_sel", alu_sel, 5);
      check("s_ab", {alu_a, alu_b}, {6'b101010, 6'b100110});
      check("s_busy", busy, 1);
      check("s_nodone", {done1, done0}, 0);
      req0 = 1'b0;
      @(negedge clk);
      check("s_done", {done1, done0}, 2'b01);
      check("s_gnt_hold", {gnt1, gnt0}, 2'b01);
      check("s_res", {ovf, cout, result}, {2'b00, 6'b110011});
      @(negedge clk);
      check("s_idle", {busy, gnt1, gnt0, done1, done0}, 0);
      check("s_alu_hold", {alu_sel, alu_a}, {3'd5, 6'b101010});
      zforce = 1'b1;
      @(negedge clk);
      check("hold_res", result, 6'b110011);
      zforce = 1'b0;
      // tie after reset: order 0,1,0
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      req0 = 1'b1; req1 = 1'b1;
      a0 = 6'd1; b0 = 6'd2; sel0 = 3'd1; a1 = 6'd3; b1 = 6'd4; sel1 = 3'd2;
      for (int k = 0; k < 3; k++) begin
         exp_g = (k == 1) ? 2'b10 : 2'b01;
         exp_a = (k == 1) ? 6'd3 : 6'd1;
         exp_b = (k == 1) ? 6'd4 : 6'd2;
         @(negedge clk);
         check("t_gnt", {gnt1, gnt0}, exp_g);
         check("t_alu", {alu_sel, alu_a, alu_b}, {(k == 1) ? 3'd2 : 3'd1, exp_a, exp_b});
         @(negedge clk);
         check("t_done", {done1, done0}, exp_g);
         check("t_res", result, (k == 1) ? 6'b111000 : 6'b111100);
         @(negedge clk);
         check("t_idle", {busy, done1, done0}, 0);
      end
      req0 = 1'b0; req1 = 1'b0;
      // operand change and req drop while in flight, then request during DONE
      req0 = 1'b1; a0 = 6'b101010; b0 = 6'b100110; sel0 = 3'd5;
      @(negedge clk);
      check("m_gnt", {gnt1, gnt0}, 2'b01);
      a0 = 6'b000000; req0 = 1'b0;
      @(negedge clk);
      check("m_done", {done1, done0}, 2'b01);
      check("m_res", result, 6'b110011);
      req1 = 1'b1;
      @(negedge clk);
      check("b_idle", {busy, gnt1, gnt0}, 0);
      req1 = 1'b0;
      @(negedge clk);
      check("b_nogrant", {busy, gnt1, gnt0}, 0);
      // reset during GRANT
      req0 = 1'b1; a0 = 6'd5; b0 = 6'd7; sel0 = 3'd4;
      @(negedge clk);
      check("r_gnt", {gnt1, gnt0}, 2'b01);
      req0 = 1'b0;
      #2 reset = 1'b1;
      #1 check_zero("r_async");
      @(negedge clk);
      check("r_nodone", {done1, done0}, 0);
      reset = 1'b0;
      req1 = 1'b1; a1 = 6'd9; b1 = 6'd6; sel1 = 3'd3;
      @(negedge clk);
      check("r_gnt1", {gnt1, gnt0}, 2'b10);
      check("r_alu", {alu_sel, alu_a, alu_b}, {3'd3, 6'd9, 6'd6});
      req1 = 1'b0;
      @(negedge clk);
      check("r_done1", {done1, done0}, 2'b10);
      check("r_res", result, 6'b110000);
      @(negedge clk);
      check("r_idle", {busy, gnt1, gnt0}, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
